// File: rtl/alarm_ring_controller.sv
// rtl/alarm_ring_controller.sv - ringing session controller fed by the alarm-match level
module alarm_ring_controller #(
   parameter  int SNOOZE_SECONDS       = 540,
   parameter  int RING_TIMEOUT_SECONDS = 60,
   parameter  int MAX_SNOOZES          = 3,
   localparam int W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
   input  logic         i_Clk,
   input  logic         i_Reset,
   input  logic         i_Tick_1Hz_Pulse,
   input  logic         i_Alarm_Enable,
   input  logic         i_Alarm_Match,
   input  logic         i_Snooze_Pulse,
   input  logic         i_Dismiss_Pulse,
   output logic         o_Alarm_On,
   output logic         o_Ringing,
   output logic         o_Snoozing,
   output logic [W-1:0] o_Snoozes_Left
);

   localparam int RW = $clog2(RING_TIMEOUT_SECONDS + 1);
   localparam int SW = $clog2(SNOOZE_SECONDS + 1);

   localparam logic [RW-1:0] RING_LAST  = RW'(RING_TIMEOUT_SECONDS - 1);
   localparam logic [RW-1:0] RING_FULL  = RW'(RING_TIMEOUT_SECONDS);
   localparam logic [SW-1:0] SNOOZE_LEN = SW'(SNOOZE_SECONDS);
   localparam logic [SW-1:0] SNOOZE_ONE = SW'(1);
   localparam logic [W-1:0]  LEFT_INIT  = W'(MAX_SNOOZES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic [RW-1:0]  ring_cnt, ring_nxt;
   logic [SW-1:0]  snooze_cnt, snooze_nxt;
   logic           phase, phase_nxt;
   logic [W-1:0]   left, left_nxt;

   // State, timers, beep phase and snooze budget registers
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state      <= IDLE;
         ring_cnt   <= '0;
         snooze_cnt <= '0;
         phase      <= 1'b0;
         left       <= LEFT_INIT;
      end else begin
         state      <= state_nxt;
         ring_cnt   <= ring_nxt;
         snooze_cnt <= snooze_nxt;
         phase      <= phase_nxt;
         left       <= left_nxt;
      end
   end

   // Next-state logic: enable drop beats dismiss beats snooze beats tick
   always_comb begin
      state_nxt  = state;
      ring_nxt   = ring_cnt;
      snooze_nxt = snooze_cnt;
      phase_nxt  = phase;
      left_nxt   = left;
      if (!i_Alarm_Enable) begin
         state_nxt = IDLE;
         left_nxt  = LEFT_INIT;
      end else begin
         case (state)
            IDLE: begin
               if (i_Alarm_Match) begin
                  state_nxt = RINGING;
                  ring_nxt  = '0;
                  phase_nxt = 1'b1;
               end
            end
            RINGING: begin
               if (i_Dismiss_Pulse) begin
                  state_nxt = DONE;
               end else if (i_Snooze_Pulse && (left != '0)) begin
                  // A tick in this same cycle is deliberately dropped
                  state_nxt  = SNOOZE;
                  snooze_nxt = SNOOZE_LEN;
                  left_nxt   = left - 1'b1;
               end else if (i_Tick_1Hz_Pulse) begin
                  phase_nxt = ~phase;
                  if (ring_cnt >= RING_LAST) begin
                     state_nxt = DONE;
                     ring_nxt  = RING_FULL;
                  end else begin
                     ring_nxt = ring_cnt + 1'b1;
                  end
               end
            end
            SNOOZE: begin
               // Match is not looked at: the snooze may outlast the match minute
               if (i_Dismiss_Pulse) begin
                  state_nxt = DONE;
               end else if (i_Tick_1Hz_Pulse) begin
                  if (snooze_cnt <= SNOOZE_ONE) begin
                     state_nxt  = RINGING;
                     snooze_nxt = '0;
                     ring_nxt   = '0;
                     phase_nxt  = 1'b1;
                  end else begin
                     snooze_nxt = snooze_cnt - 1'b1;
                  end
               end
            end
            DONE: begin
               // Hold here until the match minute ends so it cannot retrigger
               if (!i_Alarm_Match) begin
                  state_nxt = IDLE;
                  left_nxt  = LEFT_INIT;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs decode directly from registered state
   always_comb begin
      o_Ringing      = (state == RINGING);
      o_Snoozing     = (state == SNOOZE);
      o_Alarm_On     = (state == RINGING) && phase;
      o_Snoozes_Left = left;
   end

endmodule

// File: tb/tb_alarm_ring_controller.sv
// tb/tb_alarm_ring_controller.sv - scoreboard bench for alarm_ring_controller
module tb_alarm_ring_controller;

   localparam int SNZ_S = 5;
   localparam int RING_S = 4;
   localparam int MAXS = 2;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst, tick, en, match, snooze, dismiss;
   logic         alarm_on, ringing, snoozing;
   logic [W-1:0] left;

   typedef struct packed {
      logic         on;
      logic         ring;
      logic         snz;
      logic [W-1:0] left;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   tcnt = 0;

   // reference model, in seconds and counts
   int m_st;
   int m_left;
   int m_ring_secs;
   int m_snz_secs;
   localparam int S_IDLE = 0, S_RING = 1, S_SNZ = 2, S_DONE = 3;

   alarm_ring_controller #(
      .SNOOZE_SECONDS(SNZ_S),
      .RING_TIMEOUT_SECONDS(RING_S),
      .MAX_SNOOZES(MAXS)
   ) dut (
      .i_Clk(clk),
      .i_Reset(rst),
      .i_Tick_1Hz_Pulse(tick),
      .i_Alarm_Enable(en),
      .i_Alarm_Match(match),
      .i_Snooze_Pulse(snooze),
      .i_Dismiss_Pulse(dismiss),
      .o_Alarm_On(alarm_on),
      .o_Ringing(ringing),
      .o_Snoozing(snoozing),
      .o_Snoozes_Left(left)
   );

   always #5 clk = ~clk;

   task automatic model(input bit r, input bit e, input bit m, input bit s,
                        input bit d, input bit t);
      if (r) begin
         m_st = S_IDLE; m_left = MAXS; m_ring_secs = 0; m_snz_secs = 0;
      end else if (!e) begin
         m_st = S_IDLE; m_left = MAXS;
      end else begin
         case (m_st)
            S_IDLE: if (m) begin m_st = S_RING; m_ring_secs = 0; end
            S_RING: begin
               if (d) m_st = S_DONE;
               else if (s && m_left > 0) begin
                  m_st = S_SNZ; m_snz_secs = SNZ_S; m_left = m_left - 1;
               end else if (t) begin
                  m_ring_secs = m_ring_secs + 1;
                  if (m_ring_secs >= RING_S) m_st = S_DONE;
               end
            end
            S_SNZ: begin
               if (d) m_st = S_DONE;
               else if (t) begin
                  m_snz_secs = m_snz_secs - 1;
                  if (m_snz_secs == 0) begin m_st = S_RING; m_ring_secs = 0; end
               end
            end
            default: if (!m) begin m_st = S_IDLE; m_left = MAXS; end
         endcase
      end
   endtask

   // one cycle of stimulus; tick every 20 clocks unless forced
   task automatic step(input bit r, input bit e, input bit m, input bit s,
                       input bit d, input bit ft);
      exp_t x;
      bit   t;
      @(negedge clk);
      t = ft || (tcnt == 19);
      tcnt = (tcnt + 1) % 20;
      rst = r; en = e; match = m; snooze = s; dismiss = d; tick = t;
      model(r, e, m, s, d, t);
      x.ring = (m_st == S_RING);
      x.snz  = (m_st == S_SNZ);
      x.on   = (m_st == S_RING) && (m_ring_secs % 2 == 0);
      x.left = W'(m_left);
      exp_q.push_back(x);
   endtask

   task automatic run(input int n, input bit e, input bit m);
      for (int i = 0; i < n; i++) step(1'b0, e, m, 1'b0, 1'b0, 1'b0);
   endtask

   // monitor: compare every registered output update against the model
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (ringing !== x.ring) begin
            errors++;
            $display("FAIL ringing t=%0t got=%b exp=%b", $time, ringing, x.ring);
         end
         checks++;
         if (snoozing !== x.snz) begin
            errors++;
            $display("FAIL snoozing t=%0t got=%b exp=%b", $time, snoozing, x.snz);
         end
         checks++;
         if (alarm_on !== x.on) begin
            errors++;
            $display("FAIL alarm_on t=%0t got=%b exp=%b", $time, alarm_on, x.on);
         end
         checks++;
         if (left !== x.left) begin
            errors++;
            $display("FAIL snoozes_left t=%0t got=%0d exp=%0d", $time, left, x.left);
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; match = 1'b0; snooze = 1'b0; dismiss = 1'b0; tick = 1'b0;
      m_st = S_IDLE; m_left = MAXS; m_ring_secs = 0; m_snz_secs = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run(5, 1'b1, 1'b0);
      // ring until timeout, held in DONE while match stays high
      run(120, 1'b1, 1'b1);
      run(5, 1'b1, 1'b0);
      run(10, 1'b1, 1'b1);
      // snooze, ring resumes after the snooze period
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      run(110, 1'b1, 1'b0);
      // second snooze, then a third one that must be ignored
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      run(110, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      run(10, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      run(100, 1'b1, 1'b0);
      // new session: snooze and dismiss together
      run(5, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      run(5, 1'b1, 1'b1);
      run(3, 1'b1, 1'b0);
      // snooze then enable dropped mid-snooze
      run(3, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      run(30, 1'b1, 1'b0);
      run(3, 1'b0, 1'b0);
      // snooze coinciding with a tick
      run(3, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      run(5, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      run(3, 1'b1, 1'b0);
      // reset while ringing with match still high
      run(5, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run(10, 1'b1, 1'b1);
      // randomized traffic
      begin
         bit e, m, s, d, r, ft;
         e = 1'b1; m = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) e = ~e;
            if ($urandom_range(0, 59) == 0) m = ~m;
            s  = ($urandom_range(0, 29) == 0);
            d  = ($urandom_range(0, 149) == 0);
            r  = ($urandom_range(0, 799) == 0);
            ft = ($urandom_range(0, 39) == 0);
            step(r, e, m, s, d, ft);
         end
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
